ub_affine_sched_ctrl: RTL and testbench

Schedule controller for one unified buffer (`*_stencil_ub`) in a CoreIR pointwise pipeline. On a `start` pulse it walks the buffer's 3-D iteration domain twice:
- once on the producer side, driving `write_wen` and the write ctrl vars;
- once on the consumer side, a fixed `RD_DELAY` cycles later, driving `read_ren` and the read ctrl vars.

It replaces hand-wired loop counters at every ub instance and guarantees read-after-write ordering for the registered-write / combinational-read RAM.

---
 rtl/ub_sched_pkg.sv | 13 +
 rtl/ub_affine_sched_ctrl_if.sv | 23 ++
 rtl/ub_loop_counter.sv | 62 ++++++
 rtl/ub_affine_sched_ctrl.sv | 134 +++++++++++++
 tb/tb_ub_affine_sched_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ub_sched_pkg.sv
// Shared types for the unified-buffer schedule controller.
package ub_sched_pkg;
  localparam int CW = 16;

  // vars[0] = root loop, vars[1] = column, vars[2] = row
  typedef logic [2:0][CW-1:0] ctrl_vars_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;
endpackage

// File: rtl/ub_affine_sched_ctrl_if.sv
// Control inputs and ub-facing outputs of the schedule controller; state is a debug view of the FSM.
interface ub_affine_sched_ctrl_if;
  logic                     flush;
  logic                     en;
  logic                     start;
  logic                     write_wen;
  ub_sched_pkg::ctrl_vars_t write_ctrl_vars;
  logic                     read_ren;
  ub_sched_pkg::ctrl_vars_t read_ctrl_vars;
  logic                     busy;
  logic                     done;
  ub_sched_pkg::sched_state_e state;

  modport master (
    output flush, en, start,
    input  write_wen, write_ctrl_vars, read_ren, read_ctrl_vars, busy, done, state
  );

  modport slave (
    input  flush, en, start,
    output write_wen, write_ctrl_vars, read_ren, read_ctrl_vars, busy, done, state
  );
endinterface

// File: rtl/ub_loop_counter.sv
// 3-D nested loop counter: var1 innermost, then var2, var0 outermost; wraps to zero after the last point.
module ub_loop_counter import ub_sched_pkg::*; #(
  parameter int EXT0 = 1,
  parameter int EXT1 = 64,
  parameter int EXT2 = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       clr,
  output ctrl_vars_t vars,
  output logic       last
);
  localparam logic [CW-1:0] MAX0 = CW'(EXT0 - 1);
  localparam logic [CW-1:0] MAX1 = CW'(EXT1 - 1);
  localparam logic [CW-1:0] MAX2 = CW'(EXT2 - 1);

  logic [CW-1:0] v0_q, v1_q, v2_q;
  logic [CW-1:0] v0_d, v1_d, v2_d;
  logic          wrap0, wrap1, wrap2;

  assign wrap0 = (v0_q == MAX0);
  assign wrap1 = (v1_q == MAX1);
  assign wrap2 = (v2_q == MAX2);
  assign last  = wrap0 && wrap1 && wrap2;
  assign vars  = {v2_q, v1_q, v0_q};

  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    if (clr) begin
      v0_d = '0;
      v1_d = '0;
      v2_d = '0;
    end else if (step) begin
      if (wrap1) begin
        v1_d = '0;
        if (wrap2) begin
          v2_d = '0;
          v0_d = wrap0 ? '0 : v0_q + CW'(1);
        end else begin
          v2_d = v2_q + CW'(1);
        end
      end else begin
        v1_d = v1_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= '0;
      v1_q <= '0;
      v2_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end
endmodule

// File: rtl/ub_affine_sched_ctrl.sv
// Walks the ub iteration domain for the producer, then for the consumer RD_DELAY enabled cycles later.
module ub_affine_sched_ctrl import ub_sched_pkg::*; #(
  parameter int EXT0     = 1,
  parameter int EXT1     = 64,
  parameter int EXT2     = 64,
  parameter int RD_DELAY = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  ub_affine_sched_ctrl_if.slave sif
);
  localparam logic [CW-1:0] RD_W = CW'(RD_DELAY);

  if (EXT0 < 1 || EXT0 > (1 << CW) || EXT1 < 1 || EXT1 > (1 << CW) ||
      EXT2 < 1 || EXT2 > (1 << CW)) begin : g_bad_ext
    $error("ub_affine_sched_ctrl: every extent must lie in 1..2^CW");
  end
  if (RD_DELAY < 1 || RD_DELAY > 65535) begin : g_bad_delay
    $error("ub_affine_sched_ctrl: RD_DELAY must lie in 1..65535");
  end

  sched_state_e  state_q, state_d;
  logic [CW-1:0] dly_q, dly_d;
  logic          rd_on_q, rd_on_d, fin_q, fin_d;
  logic          wen_q, wen_d, ren_q, ren_d, busy_q, busy_d, done_q, done_d;
  ctrl_vars_t    wv_q, wv_d, rv_q, rv_d;
  ctrl_vars_t    wc_vars, rc_vars;
  logic          wc_last, rc_last, w_issue, r_issue, rd_go;

  ub_loop_counter #(.EXT0(EXT0), .EXT1(EXT1), .EXT2(EXT2)) u_wr_cnt (
    .clk(clk), .rst_n(rst_n), .step(w_issue), .clr(sif.flush), .vars(wc_vars), .last(wc_last)
  );
  ub_loop_counter #(.EXT0(EXT0), .EXT1(EXT1), .EXT2(EXT2)) u_rd_cnt (
    .clk(clk), .rst_n(rst_n), .step(r_issue), .clr(sif.flush), .vars(rc_vars), .last(rc_last)
  );

  // Reads run once the delay count has reached RD_DELAY, until the last point has issued.
  assign rd_go = (state_q != IDLE) && (rd_on_q || (dly_q == RD_W));

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rd_on_d = rd_on_q;
    fin_d   = fin_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wv_d    = wv_q;
    rv_d    = rv_q;
    w_issue = 1'b0;
    r_issue = 1'b0;
    if (sif.flush) begin
      state_d = IDLE;
      dly_d   = '0;
      rd_on_d = 1'b0;
      fin_d   = 1'b0;
      wen_d   = 1'b0;
      ren_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      wv_d    = '0;
      rv_d    = '0;
    end else if (sif.en) begin
      w_issue = (state_q == RUN) || ((state_q == IDLE) && sif.start);
      r_issue = rd_go;
      done_d  = 1'b0;
      if ((state_q != IDLE) && !rd_on_q) begin
        if (dly_q == RD_W) rd_on_d = 1'b1;
        else               dly_d   = dly_q + CW'(1);
      end
      // fin marks that the final read is on the outputs; completion follows one cycle later.
      if (r_issue && rc_last) begin
        rd_on_d = 1'b0;
        dly_d   = '0;
        fin_d   = 1'b1;
      end
      case (state_q)
        IDLE: if (sif.start) begin
          state_d = wc_last ? DRAIN : RUN;
          dly_d   = CW'(1);
        end
        RUN:  if (wc_last) state_d = DRAIN;
        DRAIN: if (fin_q) begin
          state_d = IDLE;
          fin_d   = 1'b0;
          dly_d   = '0;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      wen_d  = w_issue;
      wv_d   = w_issue ? wc_vars : '0;
      ren_d  = r_issue;
      rv_d   = r_issue ? rc_vars : '0;
      busy_d = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dly_q   <= '0;
      rd_on_q <= 1'b0;
      fin_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wv_q    <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rd_on_q <= rd_on_d;
      fin_q   <= fin_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wv_q    <= wv_d;
      rv_q    <= rv_d;
    end
  end

  // The ub must see no access in a frozen cycle, so the enables are masked by en directly.
  assign sif.write_wen       = wen_q && sif.en;
  assign sif.read_ren        = ren_q && sif.en;
  assign sif.write_ctrl_vars = wv_q;
  assign sif.read_ctrl_vars  = rv_q;
  assign sif.busy            = busy_q;
  assign sif.done            = done_q;
  assign sif.state           = state_q;
endmodule

// File: tb/tb_ub_affine_sched_ctrl.sv
// Scoreboard bench: three configurations exercised one after another through a shared stimulus/monitor path.
module tb_ub_affine_sched_ctrl;
  import ub_sched_pkg::*;

  localparam int W = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  logic tb_en = 1'b0, tb_start = 1'b0, tb_flush = 1'b0;
  int   sel = 0;

  ub_affine_sched_ctrl_if if_a ();
  ub_affine_sched_ctrl_if if_b ();
  ub_affine_sched_ctrl_if if_c ();

  assign if_a.en    = tb_en && (sel == 0);
  assign if_b.en    = tb_en && (sel == 1);
  assign if_c.en    = tb_en && (sel == 2);
  assign if_a.start = tb_start && (sel == 0);
  assign if_b.start = tb_start && (sel == 1);
  assign if_c.start = tb_start && (sel == 2);
  assign if_a.flush = tb_flush;
  assign if_b.flush = tb_flush;
  assign if_c.flush = tb_flush;

  ub_affine_sched_ctrl #(.EXT0(1), .EXT1(64), .EXT2(64), .RD_DELAY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .sif(if_a.slave));
  ub_affine_sched_ctrl #(.EXT0(1), .EXT1(2), .EXT2(3), .RD_DELAY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sif(if_b.slave));
  ub_affine_sched_ctrl #(.EXT0(1), .EXT1(2), .EXT2(2), .RD_DELAY(10)) dut_c (
    .clk(clk), .rst_n(rst_n), .sif(if_c.slave));

  logic         m_wen, m_ren, m_busy, m_done;
  ctrl_vars_t   m_wv, m_rv;
  sched_state_e m_state;

  always_comb begin
    m_wen = if_a.write_wen; m_ren = if_a.read_ren; m_busy = if_a.busy; m_done = if_a.done;
    m_wv = if_a.write_ctrl_vars; m_rv = if_a.read_ctrl_vars; m_state = if_a.state;
    if (sel == 1) begin
      m_wen = if_b.write_wen; m_ren = if_b.read_ren; m_busy = if_b.busy; m_done = if_b.done;
      m_wv = if_b.write_ctrl_vars; m_rv = if_b.read_ctrl_vars; m_state = if_b.state;
    end else if (sel == 2) begin
      m_wen = if_c.write_wen; m_ren = if_c.read_ren; m_busy = if_c.busy; m_done = if_c.done;
      m_wv = if_c.write_ctrl_vars; m_rv = if_c.read_ctrl_vars; m_state = if_c.state;
    end
  end

  // Entries are {cycle, {var2, var1, var0}}.
  logic [W-1:0] wexp_q[$];
  logic [W-1:0] rexp_q[$];
  logic [31:0]  dexp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, tcyc, act, exp);
    end
  endtask

  function automatic logic [47:0] pt(input int k, input int e1, input int e2);
    logic [15:0] v0, v1, v2;
    v1 = 16'(k % e1);
    v2 = 16'((k / e1) % e2);
    v0 = 16'(k / (e1 * e2));
    return {v2, v1, v0};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  d;
    if (rst_n) begin
      if (m_wen) begin
        e = (wexp_q.size() != 0) ? wexp_q.pop_front() : '1;
        check("write", {32'(tcyc), m_wv}, e);
      end
      if (m_ren) begin
        e = (rexp_q.size() != 0) ? rexp_q.pop_front() : '1;
        check("read", {32'(tcyc), m_rv}, e);
      end
      if (m_done) begin
        d = (dexp_q.size() != 0) ? dexp_q.pop_front() : '1;
        check("done_cycle", 32'(tcyc), d);
        check("done_busy", m_busy, 0);
      end
    end
  end

  task automatic issue_start(output int base);
    tb_start = 1'b1;
    base = tcyc + 1;
    @(posedge clk); #1;
    tb_start = 1'b0;
  endtask

  task automatic push_run(input int base, input int e1, input int e2, input int n,
                          input int rd, input bit stall);
    int wc, rc;
    for (int k = 0; k < n; k++) begin
      wc = k + ((stall && k >= 10) ? 5 : 0);
      rc = rd + k + ((stall && rd + k >= 10) ? 5 : 0);
      wexp_q.push_back({32'(base + wc), pt(k, e1, e2)});
      rexp_q.push_back({32'(base + rc), pt(k, e1, e2)});
    end
    dexp_q.push_back(32'(base + rd + n + (stall ? 5 : 0)));
  endtask

  task automatic run_cycles(input int ncyc, input bit stall, input bit mid_start, input bit chk65);
    for (int c = 0; c < ncyc; c++) begin
      tb_en    = !(stall && c >= 10 && c <= 14);
      tb_start = mid_start && (c == 50);
      @(negedge clk);
      check("busy_in_run", m_busy, 1);
      if (stall && (c == 10 || c == 14)) begin
        check("stall_wen", m_wen, 0);
        check("stall_ren", m_ren, 0);
        check("stall_wvars", m_wv, pt(10, 64, 64));
        check("stall_rvars", m_rv, pt(8, 64, 64));
      end
      if (chk65 && c == 65) check("write_pt65", {m_wen, m_wv}, {1'b1, 16'd1, 16'd1, 16'd0});
      @(posedge clk); #1;
    end
    tb_en = 1'b1;
    tb_start = 1'b0;
  endtask

  task automatic end_phase(input string name);
    @(negedge clk); #1;
    check({name, "_wq_left"}, wexp_q.size(), 0);
    check({name, "_rq_left"}, rexp_q.size(), 0);
    check({name, "_dq_left"}, dexp_q.size(), 0);
    check({name, "_idle"}, m_state, IDLE);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, t=%0d", tcyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int base, base2;
    logic [47:0] tab [6];
    tab[0] = 48'h0000_0000_0000;
    tab[1] = 48'h0000_0001_0000;
    tab[2] = 48'h0001_0000_0000;
    tab[3] = 48'h0001_0001_0000;
    tab[4] = 48'h0002_0000_0000;
    tab[5] = 48'h0002_0001_0000;

    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_flags", {m_wen, m_ren, m_busy, m_done}, 4'b0000);
      check("reset_vars", {m_wv, m_rv}, 96'h0);
      check("reset_state", m_state, IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_en = 1'b1;

    // Extents (1,2,3), RD_DELAY=1
    sel = 1;
    @(posedge clk); #1;
    issue_start(base);
    for (int k = 0; k < 6; k++) begin
      wexp_q.push_back({32'(base + k), tab[k]});
      rexp_q.push_back({32'(base + 1 + k), tab[k]});
    end
    dexp_q.push_back(32'(base + 7));
    run_cycles(7, 1'b0, 1'b0, 1'b0);
    end_phase("small");

    // Defaults: flush at cycle 100 together with a start, then restart, then chained stalled run
    sel = 0;
    @(posedge clk); #1;
    issue_start(base);
    for (int k = 0; k <= 100; k++) wexp_q.push_back({32'(base + k), pt(k, 64, 64)});
    for (int k = 0; k <= 98; k++)  rexp_q.push_back({32'(base + 2 + k), pt(k, 64, 64)});
    run_cycles(100, 1'b0, 1'b0, 1'b0);
    tb_flush = 1'b1;
    tb_start = 1'b1;
    @(posedge clk); #1;
    tb_flush = 1'b0;
    tb_start = 1'b0;
    @(negedge clk);
    check("flush_flags", {m_wen, m_ren, m_busy, m_done}, 4'b0000);
    check("flush_vars", {m_wv, m_rv}, 96'h0);
    check("flush_state", m_state, IDLE);
    check("flush_wq_left", wexp_q.size(), 0);
    check("flush_rq_left", rexp_q.size(), 0);
    @(posedge clk); #1;

    issue_start(base);
    push_run(base, 64, 64, 4096, 2, 1'b0);
    run_cycles(4098, 1'b0, 1'b1, 1'b1);
    issue_start(base2);
    check("chain_gap", base2 - base, 4099);
    push_run(base2, 64, 64, 4096, 2, 1'b1);
    run_cycles(4103, 1'b1, 1'b0, 1'b0);
    end_phase("default");

    // Extents (1,2,2), RD_DELAY=10
    sel = 2;
    @(posedge clk); #1;
    issue_start(base);
    push_run(base, 2, 2, 4, 10, 1'b0);
    run_cycles(14, 1'b0, 1'b0, 1'b0);
    end_phase("long_delay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
